// File: rtl/qam16_mixer.sv
// 16-QAM symbol mixer: Gray-maps 4-bit symbols to I/Q levels, holds each for
// SYM_LEN carrier samples and mixes them with the NCO pair into one real sample.
module qam16_mixer #(
  parameter int SYM_LEN = 64,
  parameter int OSHIFT  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sym_data,
  input  logic        sym_valid,
  output logic        sym_ready,
  input  logic [15:0] carr_i,
  input  logic [15:0] carr_q,
  output logic [15:0] out_sample,
  output logic        out_valid,
  output logic        sym_start,
  output logic        underrun
);

  localparam int CW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SYM_LEN - 1);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  // Gray map: adjacent constellation points differ by one bit.
  function automatic logic signed [2:0] gray_lvl(input logic [1:0] b);
    case (b)
      2'b00:   gray_lvl = -3'sd3;
      2'b01:   gray_lvl = -3'sd1;
      2'b11:   gray_lvl = 3'sd1;
      default: gray_lvl = 3'sd3;
    endcase
  endfunction

  logic                state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic signed [2:0]   lvl_i_q, lvl_i_d;
  logic signed [2:0]   lvl_q_q, lvl_q_d;
  logic                underrun_q, underrun_d;

  logic signed [18:0]  p_i_q, p_i_d;
  logic signed [18:0]  p_q_q, p_q_d;
  logic                act1_q, act1_d;
  logic                st1_q, st1_d;

  logic [15:0]         out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                sym_start_q, sym_start_d;

  logic signed [18:0]  diff;
  logic                accept;
  logic                last;

  assign last      = (cnt_q == CNT_LAST);
  assign sym_ready = (state_q == IDLE) || last;
  assign accept    = sym_valid && sym_ready;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lvl_i_d    = lvl_i_q;
    lvl_q_d    = lvl_q_q;
    underrun_d = 1'b0;
    if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      lvl_i_d = gray_lvl(sym_data[3:2]);
      lvl_q_d = gray_lvl(sym_data[1:0]);
    end else if (state_q == RUN) begin
      if (last) begin
        state_d    = IDLE;
        cnt_d      = '0;
        lvl_i_d    = '0;
        lvl_q_d    = '0;
        underrun_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Levels are zero in IDLE, so the products (and the output) fall to zero too.
  always_comb begin
    p_i_d  = lvl_i_q * $signed(carr_i);
    p_q_d  = lvl_q_q * $signed(carr_q);
    act1_d = (state_q == RUN);
    st1_d  = (state_q == RUN) && (cnt_q == '0);
  end

  // The difference fits 19 bits; OSHIFT>=3 keeps the shifted result within 16.
  always_comb begin
    diff        = p_i_q - p_q_q;
    out_d       = 16'(diff >>> OSHIFT);
    out_valid_d = act1_q;
    sym_start_d = st1_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lvl_i_q     <= '0;
      lvl_q_q     <= '0;
      underrun_q  <= 1'b0;
      p_i_q       <= '0;
      p_q_q       <= '0;
      act1_q      <= 1'b0;
      st1_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sym_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lvl_i_q     <= lvl_i_d;
      lvl_q_q     <= lvl_q_d;
      underrun_q  <= underrun_d;
      p_i_q       <= p_i_d;
      p_q_q       <= p_q_d;
      act1_q      <= act1_d;
      st1_q       <= st1_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sym_start_q <= sym_start_d;
    end
  end

  assign out_sample = out_q;
  assign out_valid  = out_valid_q;
  assign sym_start  = sym_start_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_qam16_mixer.sv
// Directed bench for qam16_mixer (SYM_LEN=4): single-symbol vector table plus
// back-to-back, gap and mid-symbol reset sequences.
module tb_qam16_mixer;

  localparam int SYM_LEN = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sym_data;
  logic        sym_valid;
  logic        sym_ready;
  logic [15:0] carr_i;
  logic [15:0] carr_q;
  logic [15:0] out_sample;
  logic        out_valid;
  logic        sym_start;
  logic        underrun;

  qam16_mixer #(.SYM_LEN(SYM_LEN), .OSHIFT(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sym_data   (sym_data),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .carr_i     (carr_i),
    .carr_q     (carr_q),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .sym_start  (sym_start),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [3:0] data;
    int         ci;
    int         cq;
    int         exp_out;
  } vec_t;

  vec_t vecs[8];

  // Scenario description consumed by run_seq: acceptance edges relative to the
  // first acceptance, symbol bits and hand-computed sample value per symbol.
  int         seq_n;
  int         seq_acc[4];
  logic [3:0] seq_dat[4];
  int         seq_exp[4];
  bit         seq_hold;

  // Called at a negedge; cycle i is the interval after acceptance-relative edge i.
  task automatic run_seq(input string tag, input int n_cyc);
    for (int i = -1; i < n_cyc; i++) begin
      bit rdy_e = 1'b1, val_e = 1'b0, st_e = 1'b0, und_e = 1'b0;
      int out_e = 0;
      int p = -1;
      for (int s = 0; s < seq_n; s++) begin
        int k = i - seq_acc[s];
        if (k >= 0 && k <= SYM_LEN - 1) rdy_e = (k == SYM_LEN - 1);
        if (k >= 2 && k <= SYM_LEN + 1) begin
          val_e = 1'b1;
          out_e = seq_exp[s];
        end
        if (k == 2) st_e = 1'b1;
        if (k == SYM_LEN && !(s + 1 < seq_n && seq_acc[s+1] == seq_acc[s] + SYM_LEN))
          und_e = 1'b1;
      end
      check($sformatf("%s c%0d sym_ready", tag, i), int'(sym_ready), int'(rdy_e));
      if (i >= 0) begin
        check($sformatf("%s c%0d out_sample", tag, i), int'($signed(out_sample)), out_e);
        check($sformatf("%s c%0d out_valid", tag, i), int'(out_valid), int'(val_e));
        check($sformatf("%s c%0d sym_start", tag, i), int'(sym_start), int'(st_e));
        check($sformatf("%s c%0d underrun", tag, i), int'(underrun), int'(und_e));
      end
      for (int s = seq_n - 1; s >= 0; s--)
        if (seq_acc[s] >= i + 1) p = s;
      sym_valid = (p >= 0) && (seq_hold || seq_acc[p] == i + 1);
      sym_data  = (p >= 0) ? seq_dat[p] : 4'h0;
      @(posedge clk);
      @(negedge clk);
    end
    sym_valid = 1'b0;
  endtask

  task automatic load_single(input int v);
    seq_n      = 1;
    seq_hold   = 1'b0;
    seq_acc[0] = 0;
    seq_dat[0] = vecs[v].data;
    seq_exp[0] = vecs[v].exp_out;
    carr_i     = 16'(vecs[v].ci);
    carr_q     = 16'(vecs[v].cq);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"p3p3",   4'b1010,   1000,      0,    375};
    vecs[1] = '{"m3m3",   4'b0000,   1000,   2000,    375};
    vecs[2] = '{"floor",  4'b0101,      1,      0,     -1};
    vecs[3] = '{"maxpos", 4'b1000,  32767,  32767,  24575};
    vecs[4] = '{"maxneg", 4'b1000, -32768, -32768, -24576};
    vecs[5] = '{"p1m1",   4'b1101,    800,   -160,     80};
    vecs[6] = '{"m1p1",   4'b0111,    100,     60,    -20};
    vecs[7] = '{"m3p1",   4'b0011,     -8,     16,      1};

    rst_n     = 1'b0;
    sym_valid = 1'b0;
    sym_data  = 4'h0;
    carr_i    = 16'd1234;
    carr_q    = 16'd567;
    #1;
    check("reset out_sample", int'(out_sample), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset sym_start", int'(sym_start), 0);
    check("reset underrun", int'(underrun), 0);
    check("reset sym_ready", int'(sym_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      load_single(v);
      run_seq(vecs[v].name, 8);
    end

    // Back-to-back: valid held high, A/B/C loaded with no idle cycles.
    seq_n = 3; seq_hold = 1'b1;
    seq_acc[0] = 0; seq_dat[0] = 4'b1010; seq_exp[0] = 375;
    seq_acc[1] = 4; seq_dat[1] = 4'b0101; seq_exp[1] = -125;
    seq_acc[2] = 8; seq_dat[2] = 4'b1111; seq_exp[2] = 125;
    carr_i = 16'd1000; carr_q = 16'd0;
    run_seq("b2b", 16);

    // Gap: second symbol arrives 3 cycles after the first one ends.
    seq_n = 2; seq_hold = 1'b0;
    seq_acc[0] = 0; seq_dat[0] = 4'b1010; seq_exp[0] = 375;
    seq_acc[1] = 7; seq_dat[1] = 4'b0101; seq_exp[1] = -125;
    run_seq("gap", 15);

    // Mid-symbol reset at cnt=2, while the first sample is on the output.
    load_single(0);
    run_seq("pre_rst", 2);
    check("pre_rst out_valid", int'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst out_sample", int'(out_sample), 0);
    check("rst out_valid", int'(out_valid), 0);
    check("rst sym_start", int'(sym_start), 0);
    check("rst underrun", int'(underrun), 0);
    check("rst sym_ready", int'(sym_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst out_sample", int'(out_sample), 0);
    check("post_rst out_valid", int'(out_valid), 0);
    check("post_rst underrun", int'(underrun), 0);
    load_single(0);
    run_seq("post_rst", 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
